tmds_channel_decoder: RTL

TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

---
 rtl/tmds_pkg.sv | 17 +
 rtl/tmds_symbol_decode.sv | 36 +++
 rtl/tmds_channel_decoder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions for the encoder and decoder sides of a channel:
// the four control-token code words and the word-alignment FSM states.
package tmds_pkg;

    // Control tokens, indexed by {c1,c0}
    localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
    localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
    localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
    localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } tmds_state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational 10b->8b TMDS decode plus control-token recognition.
// Ports: sym (10-bit word in), is_ctrl (word is a token),
//        ctrl ({c1,c0} of the token), data (decoded byte of a data symbol).
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    logic [7:0] q;

    always_comb begin
        is_ctrl = 1'b1;
        ctrl    = 2'b00;
        case (sym)
            TMDS_CTRL_00: ctrl = 2'b00;
            TMDS_CTRL_01: ctrl = 2'b01;
            TMDS_CTRL_10: ctrl = 2'b10;
            TMDS_CTRL_11: ctrl = 2'b11;
            default:      is_ctrl = 1'b0;
        endcase
    end

    // bit9 undoes the DC-balance inversion, bit8 selects XOR vs XNOR chaining
    always_comb begin
        q       = sym[9] ? ~sym[7:0] : sym[7:0];
        data[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel: word-alignment search with bitslip, lock tracking
// and registered decode of data symbols and control tokens.
// Ports: clk, rst (sync, active-high); tmds_in/tmds_valid from the
//        deserializer; bitslip back to it; locked; data_out, ctrl_out,
//        de_out, valid_out as the decoded stream (1 cycle latency).
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN_LEN   = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT_CYC  = 16,
    parameter int MAX_GAP        = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] tmds_in,
    input  logic       tmds_valid,
    output logic       bitslip,
    output logic       locked,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de_out,
    output logic       valid_out
);

    localparam int RUN_W  = $clog2(CTRL_RUN_LEN + 1);
    localparam int TO_W   = $clog2(SEARCH_TIMEOUT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT_CYC + 1);
    localparam int GAP_W  = $clog2(MAX_GAP + 1);

    // "Last" values: the word that brings a counter to its limit
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(CTRL_RUN_LEN - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(SLIP_WAIT_CYC);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(MAX_GAP - 1);

    tmds_state_e       state, state_n;
    logic [RUN_W-1:0]  run_cnt, run_n;
    logic [TO_W-1:0]   to_cnt, to_n;
    logic [WAIT_W-1:0] wait_cnt, wait_n;
    logic [GAP_W-1:0]  gap_cnt, gap_n;

    logic       bitslip_n;
    logic       valid_n;
    logic       de_n;
    logic [1:0] ctrl_n;
    logic [7:0] data_n;

    logic       sym_is_ctrl;
    logic [1:0] sym_ctrl;
    logic [7:0] sym_data;

    tmds_symbol_decode u_dec (
        .sym     (tmds_in),
        .is_ctrl (sym_is_ctrl),
        .ctrl    (sym_ctrl),
        .data    (sym_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SEARCH;
            run_cnt   <= '0;
            to_cnt    <= '0;
            wait_cnt  <= '0;
            gap_cnt   <= '0;
            bitslip   <= 1'b0;
            valid_out <= 1'b0;
            de_out    <= 1'b0;
            ctrl_out  <= 2'b00;
            data_out  <= 8'h00;
        end else begin
            state     <= state_n;
            run_cnt   <= run_n;
            to_cnt    <= to_n;
            wait_cnt  <= wait_n;
            gap_cnt   <= gap_n;
            bitslip   <= bitslip_n;
            valid_out <= valid_n;
            de_out    <= de_n;
            ctrl_out  <= ctrl_n;
            data_out  <= data_n;
        end
    end

    assign locked = (state == ST_LOCKED);

    always_comb begin
        state_n   = state;
        run_n     = run_cnt;
        to_n      = to_cnt;
        wait_n    = wait_cnt;
        gap_n     = gap_cnt;
        bitslip_n = 1'b0;
        valid_n   = 1'b0;
        de_n      = de_out;
        ctrl_n    = ctrl_out;
        data_n    = data_out;

        unique case (state)
            ST_SEARCH: begin
                if (tmds_valid) begin
                    to_n  = to_cnt + 1'b1;
                    run_n = sym_is_ctrl ? run_cnt + 1'b1 : '0;
                    // Lock wins if both limits are hit on the same word
                    if (sym_is_ctrl && run_cnt == RUN_LAST) begin
                        state_n = ST_LOCKED;
                        run_n   = '0;
                        to_n    = '0;
                        gap_n   = '0;
                    end else if (to_cnt == TO_LAST) begin
                        state_n   = ST_SLIP_WAIT;
                        bitslip_n = 1'b1;
                        run_n     = '0;
                        to_n      = '0;
                        wait_n    = '0;
                    end
                end
            end

            // Spans the bitslip pulse cycle plus SLIP_WAIT_CYC idle
            // cycles, so the deserializer settles before the next word.
            ST_SLIP_WAIT: begin
                if (wait_cnt == WAIT_MAX) begin
                    state_n = ST_SEARCH;
                    wait_n  = '0;
                    run_n   = '0;
                    to_n    = '0;
                    gap_n   = '0;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end

            ST_LOCKED: begin
                if (tmds_valid) begin
                    valid_n = 1'b1;
                    if (sym_is_ctrl) begin
                        de_n   = 1'b0;
                        data_n = 8'h00;
                        ctrl_n = sym_ctrl;
                        gap_n  = '0;
                    end else begin
                        de_n   = 1'b1;
                        data_n = sym_data;
                        if (gap_cnt == GAP_LAST) begin
                            state_n = ST_SEARCH;
                            gap_n   = '0;
                            run_n   = '0;
                            to_n    = '0;
                        end else begin
                            gap_n = gap_cnt + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_n = ST_SEARCH;
                run_n   = '0;
                to_n    = '0;
                wait_n  = '0;
                gap_n   = '0;
            end
        endcase
    end

endmodule
